// File: rtl/pulse_collector.sv
// Rising-edge collector for the demux Y/Z lines: per-channel edge counters plus an ordered tag FIFO
// drained by valid/ready. Optional per-entry timestamps under PULSE_COLLECTOR_TIMESTAMP_EN.
module pulse_collector #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8,
    parameter int TS_W  = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     y_in,
    input  logic                     z_in,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic                     out_chan,
`ifdef PULSE_COLLECTOR_TIMESTAMP_EN
    output logic [TS_W-1:0]          out_time,
`endif
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         y_count,
    output logic [CNT_W-1:0]         z_count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);

    logic              y_q, z_q;
    logic [AW:0]       wr_ptr, rd_ptr;
    logic              mem_chan [DEPTH];
`ifdef PULSE_COLLECTOR_TIMESTAMP_EN
    logic [TS_W-1:0]   ts;
    logic [TS_W-1:0]   mem_time [DEPTH];
`endif

    logic              y_edge, z_edge, pop, full;
    logic              push_y, push_z, drop;
    logic [AW+1:0]     space;
    logic [AW-1:0]     widx0, widx1;

    assign level     = wr_ptr - rd_ptr;
    assign out_valid = (wr_ptr != rd_ptr);
    assign out_chan  = mem_chan[rd_ptr[AW-1:0]];
`ifdef PULSE_COLLECTOR_TIMESTAMP_EN
    assign out_time  = mem_time[rd_ptr[AW-1:0]];
`endif

    // A pop frees its slot for writes in the same cycle; Y always claims space before Z.
    always_comb begin
        y_edge = y_in & ~y_q;
        z_edge = z_in & ~z_q;
        pop    = out_valid & out_ready;
        full   = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
        space  = (AW+2)'(DEPTH) - (AW+2)'(level) + (AW+2)'(pop);
        push_y = y_edge & (~full | pop);
        push_z = z_edge & (space > (AW+2)'(push_y));
        drop   = (y_edge & ~push_y) | (z_edge & ~push_z);
        widx0  = wr_ptr[AW-1:0];
        widx1  = wr_ptr[AW-1:0] + AW'(push_y);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            y_q      <= 1'b0;
            z_q      <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            y_count  <= '0;
            z_count  <= '0;
            overflow <= 1'b0;
        end else begin
            y_q      <= y_in;
            z_q      <= z_in;
            wr_ptr   <= wr_ptr + (AW+1)'(push_y) + (AW+1)'(push_z);
            rd_ptr   <= rd_ptr + (AW+1)'(pop);
            y_count  <= y_count + CNT_W'(y_edge);
            z_count  <= z_count + CNT_W'(z_edge);
            if (drop)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                mem_chan[i] <= 1'b0;
        end else begin
            if (push_y)
                mem_chan[widx0] <= 1'b0;
            if (push_z)
                mem_chan[widx1] <= 1'b1;
        end
    end

`ifdef PULSE_COLLECTOR_TIMESTAMP_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ts <= '0;
            for (int unsigned i = 0; i < DEPTH; i++)
                mem_time[i] <= '0;
        end else begin
            ts <= ts + 1'b1;
            if (push_y)
                mem_time[widx0] <= ts;
            if (push_z)
                mem_time[widx1] <= ts;
        end
    end
`endif

endmodule

// File: tb/tb_pulse_collector.sv
// Directed + random bench for pulse_collector against a queue-based reference model.
module tb_pulse_collector;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;
    localparam int TS_W  = 16;

    logic                   clock = 1'b0;
    logic                   reset_n = 1'b0;
    logic                   y_in = 1'b0, z_in = 1'b0, out_ready = 1'b0;
    logic                   out_valid, out_chan, overflow;
    logic [$clog2(DEPTH):0] level;
    logic [CNT_W-1:0]       y_count, z_count;
`ifdef PULSE_COLLECTOR_TIMESTAMP_EN
    logic [TS_W-1:0]        out_time;
`endif

    int tests = 0;
    int fails = 0;

    // Reference model: a queue of channel tags (and timestamps) plus plain counters.
    bit mq[$];
    int mt[$];
    int my, mz, mts;
    bit movf, myp, mzp;

    pulse_collector #(.DEPTH(DEPTH), .CNT_W(CNT_W), .TS_W(TS_W)) dut (
        .clock(clock), .reset_n(reset_n), .y_in(y_in), .z_in(z_in),
        .out_ready(out_ready), .out_valid(out_valid), .out_chan(out_chan),
`ifdef PULSE_COLLECTOR_TIMESTAMP_EN
        .out_time(out_time),
`endif
        .level(level), .y_count(y_count), .z_count(z_count), .overflow(overflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mt.delete();
        my = 0; mz = 0; mts = 0;
        movf = 0; myp = 0; mzp = 0;
    endtask

    task automatic model_clk(input bit y, input bit z, input bit r);
        bit ye, ze;
        ye = y && !myp;
        ze = z && !mzp;
        if (r && mq.size() > 0) begin
            void'(mq.pop_front());
            void'(mt.pop_front());
        end
        if (ye) begin
            if (mq.size() < DEPTH) begin mq.push_back(1'b0); mt.push_back(mts); end
            else movf = 1;
        end
        if (ze) begin
            if (mq.size() < DEPTH) begin mq.push_back(1'b1); mt.push_back(mts); end
            else movf = 1;
        end
        my  = (my + int'(ye)) % (1 << CNT_W);
        mz  = (mz + int'(ze)) % (1 << CNT_W);
        mts = (mts + 1) % (1 << TS_W);
        myp = y;
        mzp = z;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, 32'(out_valid), 32'(mq.size() != 0));
        chk({tag, ".level"}, 32'(level), 32'(mq.size()));
        if (mq.size() != 0) begin
            chk({tag, ".chan"}, 32'(out_chan), 32'(mq[0]));
`ifdef PULSE_COLLECTOR_TIMESTAMP_EN
            chk({tag, ".time"}, 32'(out_time), 32'(mt[0]));
`endif
        end
        chk({tag, ".ycnt"}, 32'(y_count), 32'(my));
        chk({tag, ".zcnt"}, 32'(z_count), 32'(mz));
        chk({tag, ".ovf"}, 32'(overflow), 32'(movf));
    endtask

    task automatic cycle(input bit y, input bit z, input bit r, input string tag);
        y_in = y; z_in = z; out_ready = r;
        model_clk(y, z, r);
        @(posedge clock);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        model_reset();
        #1;
        chk({tag, ".rst_valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".rst_level"}, 32'(level), 32'd0);
        chk({tag, ".rst_chan"}, 32'(out_chan), 32'd0);
        chk({tag, ".rst_ovf"}, 32'(overflow), 32'd0);
        chk({tag, ".rst_ycnt"}, 32'(y_count), 32'd0);
        chk({tag, ".rst_zcnt"}, 32'(z_count), 32'd0);
`ifdef PULSE_COLLECTOR_TIMESTAMP_EN
        chk({tag, ".rst_time"}, 32'(out_time), 32'd0);
`endif
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        model_reset();

        // single Y pulse
        do_reset("t1");
        cycle(1, 0, 0, "t1a");
        chk("t1.level1", 32'(level), 32'd1);
        chk("t1.chan0", 32'(out_chan), 32'd0);
        cycle(0, 0, 0, "t1b");

        // simultaneous Y+Z, drained in order
        do_reset("t2");
        cycle(1, 1, 0, "t2a");
        chk("t2.level2", 32'(level), 32'd2);
        cycle(0, 0, 1, "t2b");
        chk("t2.second_chan", 32'(out_chan), 32'd1);
        cycle(0, 0, 1, "t2c");

        // 3 Y edges then Y+Z into a 4-deep FIFO: Z dropped
        do_reset("t3");
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 0, "t3y");
            cycle(0, 0, 0, "t3l");
        end
        cycle(1, 1, 0, "t3yz");
        chk("t3.level4", 32'(level), 32'd4);
        chk("t3.ovf", 32'(overflow), 32'd1);
        chk("t3.ycnt4", 32'(y_count), 32'd4);

        // full FIFO, pop and Z push in the same cycle
        do_reset("t4");
        for (int i = 0; i < 4; i++) begin
            cycle(1, 0, 0, "t4y");
            cycle(0, 0, 0, "t4l");
        end
        cycle(0, 1, 1, "t4pp");
        chk("t4.level4", 32'(level), 32'd4);
        chk("t4.ovf0", 32'(overflow), 32'd0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, "t4d");
        chk("t4.tail_chan", 32'(out_chan), 32'd1);
        cycle(0, 0, 1, "t4e");

        // 256 Y edges with continuous ready: counter and pointer wrap
        do_reset("t5");
        for (int i = 0; i < 256; i++) begin
            cycle(1, 0, 1, "t5y");
            cycle(0, 0, 1, "t5l");
        end
        chk("t5.ywrap", 32'(y_count), 32'd0);
        chk("t5.ovf0", 32'(overflow), 32'd0);

        // reset mid-operation with level=3, overflow=1, Y held high through release
        do_reset("t6");
        for (int i = 0; i < 5; i++) begin
            cycle(1, 0, 0, "t6y");
            cycle(0, 0, 0, "t6l");
        end
        cycle(0, 0, 1, "t6p");
        chk("t6.level3", 32'(level), 32'd3);
        chk("t6.ovf1", 32'(overflow), 32'd1);
        y_in = 1'b1;
        do_reset("t6r");
        cycle(1, 0, 0, "t6h1");
        cycle(1, 0, 0, "t6h2");
        chk("t6.held_once", 32'(y_count), 32'd1);

        // random traffic
        do_reset("rnd");
        for (int i = 0; i < 500; i++)
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) == 0), "rnd");
        for (int i = 0; i < 300; i++)
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) != 0), "rnd2");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
